// File: rtl/btn_event_latch.sv
// btn_event_latch: synchronizes and debounces a raw pushbutton and turns each
// accepted press into a sticky "pending" flag that the CPU clears by reading
// the ENTER register. Also keeps a wrapping press counter and an overrun flag.
// Optional feature macro: BTN_AUTOREPEAT_EN (adds held-button auto-repeat).
module btn_event_latch #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       rd_strobe,
    output logic       pending,
    output logic       level,
    output logic [7:0] press_count,
    output logic       overrun
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    // Pin level of an unpressed button; the synchronizer resets to it.
    localparam logic            RELEASED_RAW = ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic            sync_q1;
    logic            sync_q2;
    logic            sync;
    logic [DB_W-1:0] db_cnt;
    logic            accept;
    logic            press_edge;
    logic            release_edge;
    logic            repeat_tick;
    logic            btn_event;

    // Two-flop synchronizer on the asynchronous pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= RELEASED_RAW;
            sync_q2 <= RELEASED_RAW;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Normalize so that 1 always means "pressed".
    assign sync = ACTIVE_LOW ? ~sync_q2 : sync_q2;

    // A level change is accepted on the edge that completes the stable window.
    assign accept       = (sync != level) && (db_cnt == DB_LAST);
    assign press_edge   = accept && sync;
    assign release_edge = accept && !sync;

    // Debounce: count consecutive cycles the synchronized input disagrees with
    // the accepted level; any agreement restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (accept) begin
            db_cnt <= '0;
            level  <= sync;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int              RP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
    localparam int              RP_W     = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_PERIOD - 1);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_param_check
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic [RP_W-1:0] rp_cnt;
    logic            rp_armed;   // first repeat already issued; use the period

    // A held button that is not being released this edge ticks after the
    // initial delay, then at every period.
    assign repeat_tick = level && !release_edge &&
                         (rp_cnt == (rp_armed ? RP_NEXT : RP_FIRST));

    // Repeat timer runs only while the debounced level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp_cnt   <= '0;
            rp_armed <= 1'b0;
        end else if (!level || release_edge) begin
            rp_cnt   <= '0;
            rp_armed <= 1'b0;
        end else if (repeat_tick) begin
            rp_cnt   <= '0;
            rp_armed <= 1'b1;
        end else begin
            rp_cnt <= rp_cnt + 1'b1;
        end
    end
`else
    // Repeat parameters have no effect in this build; only sanity-check them.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_repeat_param_check
        $error("REPEAT_DELAY and REPEAT_PERIOD must be non-negative");
    end

    assign repeat_tick = 1'b0;
`endif

    assign btn_event = press_edge || repeat_tick;

    // Sticky event latch: a new event beats a same-cycle read so no press is
    // lost, while the read still consumes the older press (no overrun).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= 1'b0;
            overrun     <= 1'b0;
            press_count <= 8'd0;
        end else if (btn_event) begin
            pending     <= 1'b1;
            press_count <= press_count + 8'd1;
            overrun     <= !rd_strobe && (overrun || pending);
        end else if (rd_strobe) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/btn_event_latch.md
# btn_event_latch

Debounced pushbutton event source feeding the memory-mapped ENTER register at 0xC000_0000 in `dmem`. It synchronizes and debounces the raw board key and turns each accepted press into a sticky `pending` flag. The flag holds until the CPU reads the register, so no press is lost between polling loads. It also keeps a wrapping press counter and an overrun flag for presses that arrive while a previous one is still unread.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥1.
- `ACTIVE_LOW`, default 1: 1 means pressed = `btn_raw` low (DE10 KEY); 0 means pressed = high.
- `REPEAT_DELAY`, default 25000000: cycles from accepted press to first auto-repeat; used only with `BTN_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between later auto-repeats; used only with `BTN_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `btn_raw`  in  1  raw, asynchronous pushbutton pin.
- `rd_strobe`  in  1  one-cycle pulse from `dmem` when the CPU reads 0xC000_0000.
- `pending`  out  1  sticky "unread press" flag; `dmem` returns it in bit 0 of the read data.
- `level`  out  1  debounced button state (1 = pressed).
- `press_count`  out  8  accepted-event counter; wraps.
- `overrun`  out  1  sticky flag: an event arrived while `pending` was already 1.

## Operation
- Synchronizer: two flip-flops on `btn_raw`, then polarity normalized by `ACTIVE_LOW`, giving `sync`.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - When `sync == level`, the counter is 0.
  - When `sync != level`, the counter increments each cycle.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, `level <= sync` and the counter clears.
  - Any return of `sync` to `level` before that edge clears the counter, so the glitch is rejected.
- Event: `level` 0→1 transition, plus auto-repeat ticks when configured. The release edge (1→0) is never an event.
- On event:
  - `pending <= 1`.
  - `press_count <= press_count + 1`, wrapping 255→0.
  - If `pending` is 1 and `rd_strobe` is 0 in the same cycle, `overrun <= 1`.
- On `rd_strobe`: `pending <= 0` and `overrun <= 0`.
- Event and `rd_strobe` in the same cycle:
  - `pending` ends at 1, because the set wins and the new press is not lost.
  - `overrun` ends at 0, because the old press was consumed by the read.
- `rd_strobe` with no pending event has no effect beyond clearing.
- Reset values (asynchronous, `reset` = 0): sync flops hold the released state; `level`, `pending`, `overrun` = 0; `press_count` = 0; all counters = 0.
- Reset asserted mid-debounce or mid-press: everything returns to the released state immediately. After reset releases with the button held, a full `DEBOUNCE_CYCLES` window is required, then a new event.

## Timing
- All outputs are registered and change only on rising `clk`, except during asynchronous reset.
- Latency from a stable raw change to the `level` update: 2 + `DEBOUNCE_CYCLES` rising edges.
- `pending` and `press_count` update on the same edge as `level` rising.
- `rd_strobe` sampled at edge N clears `pending` at edge N. A read issued in the same cycle as the strobe still sees the pre-edge value (1).
- Release is debounced with the same `DEBOUNCE_CYCLES` window.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - While `level` = 1, a repeat counter generates an extra event `REPEAT_DELAY` cycles after the press edge.
  - Further events follow every `REPEAT_PERIOD` cycles.
  - The repeat counter clears when `level` falls or on reset.
  - Repeat events follow all event rules above, including overrun.
- `BTN_AUTOREPEAT_EN` undefined: exactly one event per accepted press; `REPEAT_*` parameters are ignored and no repeat logic is built.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=1.
- Reset: hold `reset`=0 with `btn_raw`=0 -> `level`/`pending`/`overrun`=0 and `press_count`=0; they stay 0 for 5 cycles after release until debounce completes.
- Clean press: `btn_raw` 1→0 held 20 cycles -> `level`=1 and `pending`=1 exactly 6 edges after the change; `press_count`=1; release gives `level`=0 after 6 edges with no new event.
- Bounce: `btn_raw` low for 3 cycles, high for 2, low for 3 -> `level` stays 0 and `press_count` stays 0.
- Read race: `pending`=1, then `rd_strobe` pulse -> `pending`=0 next edge. Second press whose event edge coincides with `rd_strobe` -> `pending`=1, `overrun`=0, `press_count`=2.
- Overrun and wrap:
  - Two presses without a read -> `overrun`=1, `press_count`=2; one `rd_strobe` clears both flags.
  - Preloading 255 presses then one more -> `press_count`=0.
- With `BTN_AUTOREPEAT_EN`, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5: hold 30 cycles after `level` rises -> events at +10, +15, +20, +25, +30, so `press_count`=6.
